// File: rtl/bus_arbiter_pkg.sv
// Shared types and defaults for the two-master bus arbiter and its watchdog.
package bus_arbiter_pkg;

  // Arbiter FSM encodings; the grant bits of GNT0/GNT1 line up with the
  // one-hot grant vector so status decode stays trivial.
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_GNT0 = 2'd1,
    ARB_GNT1 = 2'd2,
    ARB_DONE = 2'd3
  } arb_state_e;

  // Value handed back to a master whose transaction was force-terminated.
  localparam logic [31:0] ARB_ERR_DATA = 32'hFFFF_FFFF;

  // Default watchdog budget in granted cycles.
  localparam int unsigned ARB_TIMEOUT_DEF = 1024;

  // One master's view of the shared bus request side.
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic        we;
    logic        rd;
  } bus_req_t;

  // One-hot owner for a given arbiter state (zero outside the grant states).
  function automatic logic [1:0] arb_grant_of(input arb_state_e s);
    logic [1:0] g;
    g = 2'b00;
    if (s == ARB_GNT0) g = 2'b01;
    if (s == ARB_GNT1) g = 2'b10;
    return g;
  endfunction

endpackage

// File: rtl/bus_arbiter_watchdog.sv
// bus_watchdog: saturating cycle counter that flags when a granted
// transaction has used its whole budget. Reusable by any bus bridge that
// needs to bound how long it waits for a slave acknowledge.
module bus_watchdog #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  // Count granted cycles; clear while idle and hold at the last value so the
  // counter can never wrap back into a "fresh" range.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (run && (count != LAST)) begin
      count <= count + CW'(1);
    end
  end

  // Expiry is only meaningful while a transaction is running.
  assign expired = run && (count == LAST);

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: shares the single mmapper bus between the CPU (master 0) and
// a DMA-capable master (master 1). Whole transactions are granted with
// round-robin tie breaking, and a watchdog terminates any transaction the
// slave never acknowledges.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ARB_IDLE | no owner; sample requests, break ties against `last`
//   ARB_GNT0 | CPU owns the bus; slave side driven from m0
//   ARB_GNT1 | DMA master owns the bus; slave side driven from m1
//   ARB_DONE | one bubble with strobes low so the finisher can deassert
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT  = ARB_TIMEOUT_DEF,
  parameter logic [31:0] ERR_DATA = ARB_ERR_DATA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] m0_a,
  input  logic [31:0] m0_d,
  input  logic        m0_we,
  input  logic        m0_rd,
  output logic [31:0] m0_spo,
  output logic        m0_ready,
  input  logic [31:0] m1_a,
  input  logic [31:0] m1_d,
  input  logic        m1_we,
  input  logic        m1_rd,
  output logic [31:0] m1_spo,
  output logic        m1_ready,
  output logic [31:0] s_a,
  output logic [31:0] s_d,
  output logic        s_we,
  output logic        s_rd,
  input  logic [31:0] s_spo,
  input  logic        s_ready,
  output logic [1:0]  grant,
  output logic        irq_timeout,
  output logic [31:0] err_addr
);

  arb_state_e state_q, state_d;
  logic       last_q, last_d;
  logic [1:0] grant_q;
  bus_req_t   m0_req, m1_req, own_req;
  logic       req0, req1;
  logic       granted;
  logic       wd_expired;
  logic       timeout_hit;

  assign m0_req = '{a: m0_a, d: m0_d, we: m0_we, rd: m0_rd};
  assign m1_req = '{a: m1_a, d: m1_d, we: m1_we, rd: m1_rd};

  assign req0 = m0_we | m0_rd;
  assign req1 = m1_we | m1_rd;

  assign granted = (state_q == ARB_GNT0) || (state_q == ARB_GNT1);

  // Owner's request bundle; m0 outside grant states keeps s_a/s_d quiet.
  assign own_req = (state_q == ARB_GNT1) ? m1_req : m0_req;

  // A slave acknowledge in the expiry cycle is a normal completion.
  assign timeout_hit = granted & wd_expired & ~s_ready;

  bus_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (~granted),
    .run     (granted),
    .expired (wd_expired)
  );

  // State and round-robin pointer. `last` starts at 1 so the CPU wins the
  // first tie out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Next-state: grant whole transactions, leave only on ack or expiry.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (req0 && req1) begin
          if (last_q) begin
            state_d = ARB_GNT0;
            last_d  = 1'b0;
          end else begin
            state_d = ARB_GNT1;
            last_d  = 1'b1;
          end
        end else if (req0) begin
          state_d = ARB_GNT0;
        end else if (req1) begin
          state_d = ARB_GNT1;
        end
      end
      ARB_GNT0, ARB_GNT1: begin
        // Dropped strobes do not release the bus; only ack or expiry do.
        if (s_ready || wd_expired) state_d = ARB_DONE;
      end
      ARB_DONE: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  // Outputs: combinational muxes selected by the current owner.
  always_comb begin
    s_a      = own_req.a;
    s_d      = own_req.d;
    s_we     = 1'b0;
    s_rd     = 1'b0;
    m0_spo   = 32'h0;
    m0_ready = 1'b0;
    m1_spo   = 32'h0;
    m1_ready = 1'b0;
    unique case (state_q)
      ARB_GNT0: begin
        s_we     = own_req.we & ~timeout_hit;
        s_rd     = own_req.rd & ~timeout_hit;
        m0_spo   = timeout_hit ? ERR_DATA : s_spo;
        m0_ready = s_ready | timeout_hit;
      end
      ARB_GNT1: begin
        s_we     = own_req.we & ~timeout_hit;
        s_rd     = own_req.rd & ~timeout_hit;
        m1_spo   = timeout_hit ? ERR_DATA : s_spo;
        m1_ready = s_ready | timeout_hit;
      end
      default: ;
    endcase
  end

  // Registered status: owner, timeout pulse and the offending address.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q     <= 2'b00;
      irq_timeout <= 1'b0;
      err_addr    <= 32'h0;
    end else begin
      grant_q     <= arb_grant_of(state_d);
      irq_timeout <= timeout_hit;
      if (timeout_hit) err_addr <= own_req.a;
    end
  end

  assign grant = grant_q;

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master arbiter that shares the single physical bus into `mmapper` between the CPU (master 0, after MMU) and a DMA-capable master (master 1, e.g. an SD card or video DMA engine). Grants whole transactions with round-robin fairness. Muxes address, data and strobes to the slave side and routes `spo`/`ready` back. A watchdog terminates any transaction that the slave never acknowledges, so a hung peripheral cannot deadlock the system.

## Interface
Parameters:
- `TIMEOUT`, 1024: cycles a granted transaction may wait for `s_ready` before forced termination; legal range 2..65535.
- `ERR_DATA`, 32'hFFFF_FFFF: value returned on `mX_spo` for a timed-out transaction.

Ports:
- `clk`  in  1  main clock (`clk_main`).
- `rst`  in  1  reset. One clock; reset is synchronous and active-high.
- `m0_a`/`m1_a`  in  32  master address.
- `m0_d`/`m1_d`  in  32  master write data.
- `m0_we`/`m1_we`  in  1  write strobe.
- `m0_rd`/`m1_rd`  in  1  read strobe.
- `m0_spo`/`m1_spo`  out  32  read data to master.
- `m0_ready`/`m1_ready`  out  1  transaction complete.
- `s_a`  out  32  address to mmapper.
- `s_d`  out  32  write data to mmapper.
- `s_we`  out  1  write strobe to mmapper.
- `s_rd`  out  1  read strobe to mmapper.
- `s_spo`  in  32  read data from mmapper.
- `s_ready`  in  1  completion from mmapper.
- `grant`  out  2  one-hot current owner (debug/status).
- `irq_timeout`  out  1  one-cycle pulse on forced termination.
- `err_addr`  out  32  address of the last timed-out transaction.

## Operation
- Request: `reqX = mX_we | mX_rd`. A master holds `a`, `d` and strobes stable until it samples `mX_ready=1`, then may drop or change them.
- States: IDLE, GNT0, GNT1, DONE.
- IDLE:
  - Only one `reqX` set: go to GNTX.
  - Both set: grant the master that is not `last`, then set `last` to the granted master.
  - Neither set: stay in IDLE.
- GNTX:
  - `s_*` are driven combinationally from master X.
  - `mX_spo = s_spo` and `mX_ready = s_ready`.
  - The other master sees `ready=0` and `spo=0`.
  - `s_ready=1`: go to DONE.
  - Watchdog reaches `TIMEOUT-1` without `s_ready`: drive `s_we=s_rd=0`, `mX_spo=ERR_DATA`, `mX_ready=1` for that cycle, pulse `irq_timeout`, load `err_addr<=mX_a`, go to DONE.
- DONE: one bubble cycle with strobes low, so the finishing master can deassert. Then go to IDLE.
- Watchdog: counter clears on entry to GNTX and increments each GNTX cycle. Width is `$clog2(TIMEOUT)`; it never wraps.
- In IDLE and DONE: `s_we=s_rd=0`, and `s_a`/`s_d` are driven from m0 (don't-care).
- Simultaneous `s_ready` and timeout in the same cycle: `s_ready` wins; this is a normal completion with no irq.
- Strobes dropped by the granted master before `ready`: protocol violation. The arbiter stays in GNTX until `s_ready` or timeout.

## Timing
- Reset values: state IDLE, `grant=2'b00`, `last=1` (so the CPU wins the first tie), counter 0, `irq_timeout=0`, `err_addr=0`, all `mX_ready=0`, `mX_spo=0`, `s_we=s_rd=0`.
- Reset asserted mid-transaction aborts it immediately. No `ready` is returned; the master must be reset too.
- Arbitration latency: request sampled in IDLE, grant in the next cycle. Slave sees strobes 1 cycle after the request.
- Single-cycle slave: request at T, GNT at T+1 with `ready` at T+1, DONE at T+2, IDLE at T+3. Throughput is one transaction per 3 cycles per master.
- Timeout: the `ready`/irq pulse occurs in the `TIMEOUT`-th GNT cycle.
- `grant`, `irq_timeout` and `err_addr` are registered. The `s_*`/`mX_*` paths are combinational muxes selected by state.

## Structure
- Add to shared header `pCPU.vh`: state encodings (`ARB_IDLE`, `ARB_GNT0`, `ARB_GNT1`, `ARB_DONE`) and default `ARB_ERR_DATA`.
- One sub-module, `bus_watchdog`:
  - Parameter `TIMEOUT`.
  - Ports `clk`, `rst`, `clear`, `run`, `expired`.
  - Reusable by other bus bridges.
- Grant logic, muxes and error registers stay in `bus_arbiter`.

## Test plan
- Lone CPU read of `0x1000_0004`, slave `ready` 1 cycle later with `spo=0x12345678` -> `m0_spo=0x12345678`, `m0_ready` high for one cycle, `grant` sequence 00,01,00,00.
- Both masters request in the same IDLE cycle after reset -> m0 granted first. After its completion and bubble, m1 granted. Repeated simultaneous requests alternate 0,1,0,1.
- m1 write `d=0xCAFEBABE` while m0 is granted -> `s_we` stays with m0 until m0 completes. m1 gets `s_d=0xCAFEBABE` exactly one GNT1 phase later. `m1_ready` is never high during GNT0.
- `TIMEOUT=8`, slave never ready, m1 read of `0x9000_0000` -> in the 8th GNT1 cycle: `m1_spo=0xFFFFFFFF`, `m1_ready=1`, `irq_timeout` pulses once, `err_addr=0x9000_0000`. Then DONE, then IDLE.
- `s_ready` arrives in the same cycle as expiry -> normal data returned, no `irq_timeout`, `err_addr` unchanged.
- `rst` asserted during GNT1 with a 5-cycle slave -> next cycle: IDLE, `grant=00`, strobes low. After release, a tie grants m0.
